uart_tx_feeder: RTL and testbench
=================================

Name: uart_tx_feeder

Overview:
- Transmit-side front end for UART_Protocol; sits directly upstream and drives its send/data_in inputs.
- Buffers bytes from the system side in a FIFO.
- Pulses send to the UART only when it is free, holding send and data for at least one bit time.
- Confirms acceptance by watching busy, and retries or drops bytes the UART does not take.

Parameters:
DEPTH, 16, FIFO entries (power of two)
ADDR_W, 4, log2(DEPTH)
SEND_HOLD, 44, max clocks send is held waiting for busy to rise (≥ one baud period of 40 clocks)
GAP_CYCLES, 40, guard clocks after busy falls before the next send (covers stop bit)
MAX_RETRY, 3, unaccepted send attempts before the head byte is dropped

Ports:
clk  in  1  system clock, same clock as UART_Protocol
reset  in  1  asynchronous, active-low reset (0 = reset)
wr_en  in  1  write strobe; one byte per cycle
wr_data  in  8  byte to queue
full  out  1  FIFO full
empty  out  1  FIFO empty
level  out  ADDR_W+1  entries currently stored, 0..DEPTH
overflow  out  1  one-cycle pulse: write attempted while full; byte discarded
uart_send  out  1  to UART_Protocol.send
uart_data  out  8  to UART_Protocol.data_in
uart_busy  in  1  from UART_Protocol.busy; synchronous to clk
tx_drop  out  1  one-cycle pulse: head byte discarded after MAX_RETRY failed attempts

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO empties; pointers, level and counters go to 0.
  - Outputs: full=0, empty=1, overflow=0, uart_send=0, uart_data=0x00, tx_drop=0.
  - FSM goes to IDLE.
- Mid-operation reset: deassert send immediately and discard all queued bytes. A byte already taken by the UART is the UART's concern.
- FIFO:
  - Write is accepted when wr_en=1 and full=0 (full as seen at that clock edge).
  - wr_en=1 with full=1: byte ignored, overflow=1 next cycle. This holds even if a pop occurs in the same cycle.
  - Simultaneous accepted write and pop: level unchanged.
  - Pointers wrap modulo DEPTH.
  - full = (level==DEPTH); empty = (level==0).
- FSM states: IDLE, SEND, WAIT_DONE, GAP.
  - IDLE: when empty=0 and uart_busy=0, go to SEND next cycle. On that edge uart_data<=FIFO head and uart_send<=1; hold counter and retry counter are loaded.
  - SEND:
    - uart_send=1; uart_data stable, no change while in SEND.
    - If uart_busy=1: next cycle uart_send=0, pop head, retry counter cleared, go to WAIT_DONE.
    - Else, after SEND_HOLD cycles in SEND: uart_send=0, retry counter +1, go to GAP without popping.
    - If the retry counter reaches MAX_RETRY: pop head, pulse tx_drop, go to GAP.
  - WAIT_DONE: uart_send=0; when uart_busy=0, go to GAP.
  - GAP: uart_send=0; count GAP_CYCLES clocks, then go to IDLE. After a retry, the same head byte is re-presented.
- Latency: byte written into an empty FIFO with UART idle produces uart_send=1 two cycles after the wr_en edge (one cycle to store, one to launch).
- uart_data holds its last value when uart_send=0. Only an entry into SEND changes it.
- uart_busy rising in IDLE or GAP (not caused by this block): no action. IDLE waits for busy=0.
- Minimum spacing between consecutive send rising edges = one frame + GAP_CYCLES. Back-to-back queued bytes are never presented during the UART stop bit.

Test Plan:
- Single byte: write 0x18 into the empty FIFO, model busy rising 3 cycles after send → uart_send high for exactly 4 cycles with uart_data=0x18; level 1→0 on pop; next send only after busy falls + 40 clocks.
- Burst: write 0x55,0xAA,0xFF,0x0F back-to-back → four separate send pulses in order, each after the previous busy fall + GAP_CYCLES; no send while busy=1; empty=1 at the end.
- Full/overflow: with busy held 1, write 17 bytes → level=16, full=1, 17th write gives a one-cycle overflow pulse and is not stored; a write in the same cycle as a pop while full is still rejected.
- Non-accepting UART: busy tied 0, write 0x25 → three send pulses of 44 cycles each, separated by 40-cycle gaps, all with data 0x25; tx_drop pulse after the 3rd; level returns to 0.
- Reset mid-send: queue 0x51,0x96,0x48; assert reset=0 while in SEND → uart_send=0 immediately (asynchronous), empty=1, level=0, uart_data=0x00. After release, nothing is sent until a new write.
- Wrap-around: perform 40 write/send cycles with incrementing data 0x00..0x27 → the UART sees the exact sequence with no loss or duplication across pointer wrap.

Source files
------------

// File: rtl/uart_tx_feeder.sv
// Transmit front end for UART_Protocol: byte FIFO plus a launch FSM that presents
// each head byte, confirms acceptance through busy, and retries or drops it.
module uart_tx_feeder #(
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4,
  parameter int SEND_HOLD  = 44,
  parameter int GAP_CYCLES = 40,
  parameter int MAX_RETRY  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic              uart_send,
  output logic [7:0]        uart_data,
  input  logic              uart_busy,
  output logic              tx_drop
);

  localparam int CNT_MAX = (SEND_HOLD > GAP_CYCLES) ? SEND_HOLD : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int RTY_W   = $clog2(MAX_RETRY + 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_DONE, GAP} state_t;

  state_t              state, state_d;
  logic [7:0]          mem [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr, rd_ptr;
  logic                push, pop;
  logic [CNT_W-1:0]    cnt, cnt_d;
  logic [RTY_W-1:0]    retry, retry_d;
  logic                send_d, drop_d;
  logic [7:0]          data_d;

  assign full  = (level == (ADDR_W+1)'(DEPTH));
  assign empty = (level == '0);
  assign push  = wr_en && !full;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      // full is the pre-edge value, so a write colliding with a pop while full is rejected
      overflow <= wr_en && full;
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + (ADDR_W+1)'(1);
        2'b01:   level <= level - (ADDR_W+1)'(1);
        default: level <= level;
      endcase
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    retry_d = retry;
    send_d  = uart_send;
    data_d  = uart_data;
    drop_d  = 1'b0;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && !uart_busy) begin
          state_d = SEND;
          send_d  = 1'b1;
          data_d  = mem[rd_ptr];
          cnt_d   = '0;
        end
      end
      SEND: begin
        if (uart_busy) begin
          send_d  = 1'b0;
          pop     = 1'b1;
          retry_d = '0;
          state_d = WAIT_DONE;
        end else if (cnt == CNT_W'(SEND_HOLD - 1)) begin
          send_d  = 1'b0;
          cnt_d   = '0;
          state_d = GAP;
          // retry count survives the GAP/IDLE round trip; only pop or drop clears it
          if (retry == RTY_W'(MAX_RETRY - 1)) begin
            pop     = 1'b1;
            drop_d  = 1'b1;
            retry_d = '0;
          end else begin
            retry_d = retry + RTY_W'(1);
          end
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      WAIT_DONE: begin
        if (!uart_busy) begin
          state_d = GAP;
          cnt_d   = '0;
        end
      end
      GAP: begin
        if (cnt == CNT_W'(GAP_CYCLES - 1)) state_d = IDLE;
        else                                cnt_d   = cnt + CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      retry     <= '0;
      uart_send <= 1'b0;
      uart_data <= '0;
      tx_drop   <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      retry     <= retry_d;
      uart_send <= send_d;
      uart_data <= data_d;
      tx_drop   <= drop_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Scoreboarded bench for uart_tx_feeder: a behavioural UART drives busy, a queue
// holds the bytes expected on the wire, and a negedge monitor checks every output.
module tb_uart_tx_feeder;

  localparam int DEPTH      = 16;
  localparam int ADDR_W     = 4;
  localparam int SEND_HOLD  = 44;
  localparam int GAP_CYCLES = 40;
  localparam int MAX_RETRY  = 3;
  localparam int ACC_LAT    = 3;

  localparam int M_ACCEPT = 0;
  localparam int M_REJECT = 1;
  localparam int M_RANDOM = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              wr_en = 1'b0;
  logic [7:0]        wr_data = '0;
  logic              full, empty, overflow, uart_send, tx_drop;
  logic [ADDR_W:0]   level;
  logic [7:0]        uart_data;
  logic              uart_busy;
  logic              force_busy = 1'b0;
  logic              frame_busy = 1'b0;

  assign uart_busy = force_busy | frame_busy;

  uart_tx_feeder #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .SEND_HOLD(SEND_HOLD),
    .GAP_CYCLES(GAP_CYCLES), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .level(level), .overflow(overflow),
    .uart_send(uart_send), .uart_data(uart_data), .uart_busy(uart_busy),
    .tx_drop(tx_drop)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got[$];
  bit         exp_ovf = 0;
  int         mode = M_ACCEPT;
  int         rises = 0;
  int         drops = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural UART: takes a byte after the send has been visible ACC_LAT+1 samples.
  int  u_cnt = 0;
  int  u_left = 0;
  bit  u_take = 0;
  always @(posedge clk) begin
    #1;
    if (!reset) begin
      frame_busy = 1'b0;
      u_cnt = 0;
    end else if (frame_busy) begin
      u_left--;
      if (u_left == 0) frame_busy = 1'b0;
    end else if (uart_send) begin
      if (u_cnt == 0)
        u_take = (mode == M_ACCEPT) || (mode == M_RANDOM && $urandom_range(0, 3) != 0);
      u_cnt++;
      if (u_take && u_cnt == ACC_LAT + 1) begin
        frame_busy = 1'b1;
        u_left = $urandom_range(8, 40);
      end
    end else begin
      u_cnt = 0;
    end
  end

  // Monitor / scoreboard
  bit         in_pulse = 0;
  bit         seen_busy = 0;
  int         plen = 0;
  int         low_cnt = GAP_CYCLES;
  int         tries = 0;
  logic [7:0] pulse_data = '0;
  always @(negedge clk) begin
    if (!reset) begin
      in_pulse = 0;
      low_cnt  = GAP_CYCLES;
      exp_ovf  = 0;
      tries    = 0;
    end else begin
      if (uart_send && !in_pulse) begin
        rises++;
        check("send_has_byte", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("send_data", uart_data, exp_q[0]);
        check("send_gap", low_cnt >= GAP_CYCLES, 1);
        check("send_not_busy", uart_busy, 0);
        in_pulse   = 1;
        plen       = 0;
        seen_busy  = 0;
        pulse_data = uart_data;
      end
      if (in_pulse && uart_send) begin
        plen++;
        check("data_stable", uart_data, pulse_data);
        if (uart_busy) seen_busy = 1;
      end
      if (!uart_send && in_pulse) begin
        in_pulse = 0;
        if (seen_busy) begin
          check("accept_len", plen, ACC_LAT + 1);
          check("no_drop_on_accept", tx_drop, 0);
          if (exp_q.size() > 0) got.push_back(exp_q.pop_front());
          tries = 0;
        end else begin
          check("hold_len", plen, SEND_HOLD);
          tries++;
          if (tries == MAX_RETRY) begin
            check("tx_drop_pulse", tx_drop, 1);
            drops++;
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            tries = 0;
          end else begin
            check("no_early_drop", tx_drop, 0);
          end
        end
      end else if (tx_drop) begin
        check("stray_drop", tx_drop, 0);
      end
      if (uart_send || frame_busy) low_cnt = 0;
      else                         low_cnt++;
      check("level", level, exp_q.size());
      check("full", full, exp_q.size() == DEPTH);
      check("empty", empty, exp_q.size() == 0);
      check("overflow", overflow, exp_ovf);
      exp_ovf = 0;
    end
  end

  // Called at posedge+1; returns at the next posedge+1.
  task automatic do_write(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    @(posedge clk);
    if (exp_q.size() < DEPTH) exp_q.push_back(b);
    else                      exp_ovf = 1;
    #1 wr_en = 1'b0;
  endtask

  task automatic drain(input string name, input int limit);
    int n = 0;
    while ((exp_q.size() != 0 || uart_send || uart_busy) && n < limit) begin
      @(posedge clk);
      n++;
    end
    check({"drain_", name}, n < limit, 1);
    repeat (GAP_CYCLES + 4) @(posedge clk);
    #1;
  endtask

  task automatic summary();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
  endtask

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    summary();
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, d0, n;
    #1 reset = 1'b0;
    #12;
    check("rst_full", full, 0);
    check("rst_empty", empty, 1);
    check("rst_level", level, 0);
    check("rst_overflow", overflow, 0);
    check("rst_send", uart_send, 0);
    check("rst_data", uart_data, 0);
    check("rst_drop", tx_drop, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // single byte with two-cycle launch latency
    mode = M_ACCEPT;
    do_write(8'h18);
    check("launch_not_early", uart_send, 0);
    @(posedge clk); #1;
    check("launch_latency", uart_send, 1);
    check("launch_data", uart_data, 8'h18);
    drain("single", 500);

    // burst
    do_write(8'h55); do_write(8'hAA); do_write(8'hFF); do_write(8'h0F);
    drain("burst", 2000);

    // full / overflow, then writes racing the first pop
    force_busy = 1'b1;
    for (int unsigned i = 0; i < 17; i++) do_write(8'($urandom));
    check("filled_level", level, DEPTH);
    check("filled_full", full, 1);
    force_busy = 1'b0;
    for (int unsigned i = 0; i < 12; i++) do_write(8'($urandom));
    drain("overflow", 8000);

    // non-accepting UART
    mode = M_REJECT;
    r0 = rises; d0 = drops;
    do_write(8'h25);
    drain("reject", 1000);
    check("reject_attempts", rises - r0, MAX_RETRY);
    check("reject_drops", drops - d0, 1);
    mode = M_ACCEPT;

    // reset mid-send
    do_write(8'h51); do_write(8'h96); do_write(8'h48);
    n = 0;
    while (!uart_send && n < 50) begin @(negedge clk); n++; end
    check("reset_reached_send", uart_send, 1);
    #2 reset = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_send", uart_send, 0);
    check("mid_rst_empty", empty, 1);
    check("mid_rst_level", level, 0);
    check("mid_rst_data", uart_data, 0);
    check("mid_rst_full", full, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    r0 = rises;
    repeat (100) @(posedge clk);
    #1;
    check("post_rst_quiet", rises - r0, 0);

    // wrap-around: 40 incrementing bytes
    got.delete();
    for (int unsigned i = 0; i < 40; i++) begin
      while (exp_q.size() >= DEPTH) begin @(posedge clk); #1; end
      do_write(8'(i));
    end
    drain("wrap", 10000);
    check("wrap_count", got.size(), 40);
    for (int i = 0; i < got.size(); i++) check("wrap_seq", got[i], i);

    // randomized traffic with a UART that sometimes refuses
    mode = M_RANDOM;
    for (int unsigned i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      do_write(8'($urandom));
    end
    drain("random", 20000);

    summary();
    $finish;
  end

endmodule
